prg_dma_loader: RTL and testbench
=================================

// Module: prg_dma_loader
// PURPOSE
//  Turns the HPS ioctl byte stream of a .PRG download into DMA writes into PET main RAM.
//  The stream is a 2-byte little-endian load address followed by payload bytes.
//  Sits between hps_io and the pet2001hw DMA port, and replaces the inline loader in emu.
//  After the last payload byte it writes the BASIC end-of-program pointer so that RUN works.
//  Holds writes in a small FIFO, so payload is only committed when the hardware grants a DMA slot.
// PARAMETERS
//  INDEX      8'h41     ioctl_index value that selects this loader
//  LIMIT      16'h8000  first address that is NOT writable; payload at or above it is dropped
//  PTR_ADDR   16'h002A  address of the pointer low byte; the high byte goes to PTR_ADDR+1
//  FIFO_DEPTH 4         (addr,data) entries; power of two, >=2
// PORTS
//  clk             in   1   system clock (clk_sys)
//  reset           in   1   asynchronous, active-high
//  ioctl_download  in   1   a download is in progress
//  ioctl_index     in   8   download target; this block acts only when it equals INDEX
//  ioctl_wr        in   1   ioctl_dout is valid this cycle
//  ioctl_addr      in   25  byte offset within the file
//  ioctl_dout      in   8   file byte
//  ioctl_wait      out  1   backpressure to hps_io
//  dma_addr        out  16  RAM address of the FIFO head (or of a pointer write)
//  dma_din         out  8   data to write
//  dma_we          out  1   write request; held until accepted
//  dma_ack         in   1   write accepted this cycle when dma_we&&dma_ack
//  busy            out  1   any state other than IDLE
//  done            out  1   one-cycle pulse when the pointer write completes
//  overflow        out  1   sticky flag: a payload byte was dropped at or above LIMIT
// BEHAVIOUR
//  Reset (async): state=IDLE, FIFO empty, all outputs 0, pointer=0.
//  "sel" = ioctl_download && ioctl_index==INDEX.
//  States:
//   IDLE  -> HDR on the rising edge of sel; clears overflow and the FIFO.
//   HDR   ioctl_wr at offset 0 loads ptr[7:0]; offset 1 loads ptr[15:8] -> DATA.
//   DATA  each ioctl_wr with offset>=2:
//          ptr<LIMIT:  push {ptr,dout} and increment ptr.
//          otherwise:  drop the byte, set overflow, and leave ptr unchanged (it saturates).
//   On the falling edge of sel in HDR: file too short -> IDLE. No writes, no done.
//   On the falling edge of sel in DATA -> DRAIN.
//   DRAIN  waits until the FIFO is empty and no transfer is pending -> PLO.
//   PLO    dma_addr=PTR_ADDR,   dma_din=ptr[7:0],  dma_we=1; on ack -> PHI.
//   PHI    dma_addr=PTR_ADDR+1, dma_din=ptr[15:8], dma_we=1; on ack -> IDLE with done=1 for 1 cycle.
//  FIFO is first-word fall-through:
//   - A push on edge N makes dma_we=1 with the head addr/data during cycle N+1.
//   - Pop happens on the dma_we&&dma_ack edge.
//   - A push and a pop in the same cycle keep the count unchanged.
//   - A push when the FIFO is full is a design error; the ioctl_wait rule below prevents it.
//  dma_addr/dma_din must stay stable while dma_we=1 and ack is low. dma_we drops the cycle after the
//   last ack unless another entry is present.
//  ioctl_wait=1 when count>=FIFO_DEPTH-1, or state in {DRAIN,PLO,PHI}; otherwise 0.
//   One cycle of hps_io reaction slack is covered by the spare entry.
//  ioctl traffic with a different index, or while ioctl_download=0, is ignored in every state.
//   No DMA is issued for it.
//  ioctl_addr bits above [0] matter only to tell header (0/1) from payload (>=2). There is no
//   25-bit wrap handling: files longer than 64 KiB simply saturate at LIMIT.
//  The pointer written equals the address after the last stored byte, i.e.:
//   - LIMIT if truncated;
//   - the header address itself if the header was >= LIMIT or the payload was empty.
//  Async reset mid-transfer aborts immediately. No pointer write and no done.
//   Partially written RAM is left as is.
//  The rising edge of sel is ignored unless state==IDLE; the FSM finishes the current load first.
// TESTING
//  1. Header 01 04, payload AA BB CC, dma_ack tied 1
//     -> writes 0401=AA, 0402=BB, 0403=CC, then 002A=04, 002B=04; done pulses once; overflow=0.
//  2. Same file with dma_ack low for 10 cycles
//     -> ioctl_wait rises when count reaches 3; no byte is lost or reordered; addr/data stable while stalled.
//  3. Header FE 7F, payload 11 22 33 44
//     -> only 7FFE=11 and 7FFF=22 are written; overflow=1; pointer bytes 00 80.
//  4. Download of 1 byte only
//     -> no dma_we at any time; done never pulses; back to IDLE.
//  5. Async reset asserted during DRAIN with 2 entries queued
//     -> dma_we=0 immediately, FIFO empty, no pointer write; the next download works normally.
//  6. A download with ioctl_index=1 interleaved with an idle loader
//     -> no dma_we, busy stays 0, ioctl_wait stays 0.

Source files
------------

// File: rtl/prg_dma_loader.sv
// prg_dma_loader: turns the hps_io byte stream of a .PRG download into DMA
// writes into PET main RAM. The first two file bytes are a little-endian load
// address; each following byte is queued in a small first-word fall-through
// FIFO as an (addr,data) pair and written whenever the DMA port accepts it.
// After the last payload byte has been written, the BASIC end-of-program
// pointer is written to PTR_ADDR/PTR_ADDR+1.
module prg_dma_loader #(
    parameter logic [7:0]  INDEX      = 8'h41,
    parameter logic [15:0] LIMIT      = 16'h8000,
    parameter logic [15:0] PTR_ADDR   = 16'h002A,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_din,
    output logic        dma_we,
    input  logic        dma_ack,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_DRAIN,
        S_PLO,
        S_PHI
    } state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } entry_t;

    state_t          state, state_nx;
    logic            sel, sel_q, sel_rise, sel_fall;
    logic [15:0]     ptr;
    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            fifo_full, fifo_nonempty;
    logic            sel_wr, hdr_lo, hdr_hi, pay_wr, below_limit;
    logic            push, pop, fifo_clear;

    assign sel      = ioctl_download && (ioctl_index == INDEX);
    assign sel_rise = sel && !sel_q;
    assign sel_fall = !sel && sel_q;

    // Only the distinction 0 / 1 / >=2 of the file offset matters here.
    assign sel_wr      = sel && ioctl_wr;
    assign hdr_lo      = sel_wr && (state == S_HDR) && (ioctl_addr == 25'd0);
    assign hdr_hi      = sel_wr && (state == S_HDR) && (ioctl_addr == 25'd1);
    assign pay_wr      = sel_wr && (state == S_DATA) && (|ioctl_addr[24:1]);
    assign below_limit = (ptr < LIMIT);

    assign fifo_full     = (count == CW'(FIFO_DEPTH));
    assign fifo_nonempty = (count != '0);
    assign fifo_clear    = (state == S_IDLE) && sel_rise;
    assign push          = pay_wr && below_limit && !fifo_full;
    // The FIFO is only non-empty in DATA/DRAIN, so a pop never collides with a pointer write.
    assign pop           = fifo_nonempty && dma_ack;

    assign busy       = (state != S_IDLE);
    assign ioctl_wait = (count >= CW'(FIFO_DEPTH - 1)) ||
                        (state == S_DRAIN) || (state == S_PLO) || (state == S_PHI);

    // State register, edge detector, load pointer, sticky overflow and done pulse.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            sel_q    <= 1'b0;
            ptr      <= 16'h0000;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nx;
            sel_q <= sel;
            done  <= (state == S_PHI) && dma_ack;
            if (hdr_lo)
                ptr[7:0] <= ioctl_dout;
            else if (hdr_hi)
                ptr[15:8] <= ioctl_dout;
            else if (push)
                ptr <= ptr + 16'd1;
            if (fifo_clear)
                overflow <= 1'b0;
            else if (pay_wr && !below_limit)
                overflow <= 1'b1;
        end
    end

    // FIFO read/write pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (fifo_clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // FIFO storage; contents are only observed through a valid count.
    // NOTE: the storage array has no reset; stale entries are never visible while count is zero.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{addr: ptr, data: ioctl_dout};
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (sel_rise) state_nx = S_HDR;
            S_HDR:   if (sel_fall) state_nx = S_IDLE;
                     else if (hdr_hi) state_nx = S_DATA;
            S_DATA:  if (sel_fall) state_nx = S_DRAIN;
            S_DRAIN: if (!fifo_nonempty) state_nx = S_PLO;
            S_PLO:   if (dma_ack) state_nx = S_PHI;
            S_PHI:   if (dma_ack) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // DMA request mux: pointer bytes in PLO/PHI, otherwise the FIFO head.
    always_comb begin
        dma_we   = 1'b0;
        dma_addr = 16'h0000;
        dma_din  = 8'h00;
        case (state)
            S_PLO: begin
                dma_we   = 1'b1;
                dma_addr = PTR_ADDR;
                dma_din  = ptr[7:0];
            end
            S_PHI: begin
                dma_we   = 1'b1;
                dma_addr = 16'(PTR_ADDR + 16'd1);
                dma_din  = ptr[15:8];
            end
            default: begin
                if (fifo_nonempty) begin
                    dma_we   = 1'b1;
                    dma_addr = mem[rd_ptr].addr;
                    dma_din  = mem[rd_ptr].data;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_prg_dma_loader.sv
// Self-checking bench for prg_dma_loader: table-driven .PRG downloads plus
// hand-written sequences for DMA stalls, reset during DRAIN and foreign index.
module tb_prg_dma_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [15:0] dma_addr;
    logic [7:0]  dma_din;
    logic        dma_we;
    logic        dma_ack;
    logic        busy;
    logic        done;
    logic        overflow;

    prg_dma_loader dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .dma_addr       (dma_addr),
        .dma_din        (dma_din),
        .dma_we         (dma_we),
        .dma_ack        (dma_ack),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // DMA acknowledge driver: ack high unless disabled or inside a stall window.
    int   cyc         = 0;
    int   stall_until = 0;
    logic ack_en      = 1'b1;
    always @(negedge clk) begin
        cyc++;
        dma_ack = ack_en && (cyc >= stall_until);
    end

    // Monitor: logs accepted writes, counts done pulses and dma_we cycles,
    // and checks the request stays stable while stalled.
    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t         log_q[$];
    int          done_cnt = 0;
    int          we_cnt   = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_a;
    logic [7:0]  prev_d;
    always @(negedge clk) begin
        #2;
        if (dma_we && dma_ack) log_q.push_back('{a: dma_addr, d: dma_din});
        if (dma_we) we_cnt++;
        if (done) done_cnt++;
        if (prev_stall && dma_we) begin
            check("stall_addr", 32'(dma_addr), 32'(prev_a));
            check("stall_din", 32'(dma_din), 32'(prev_d));
        end
        prev_stall = dma_we && !dma_ack;
        prev_a     = dma_addr;
        prev_d     = dma_din;
    end

    typedef struct packed {
        logic [7:0][7:0]  bytes;
        logic [3:0]       nbytes;
        logic [3:0]       nexp;
        logic [7:0][15:0] ea;
        logic [7:0][7:0]  ed;
        logic             edone;
        logic             eovf;
    } vec_t;
    vec_t vecs [5];

    task automatic clear_log();
        log_q.delete();
        done_cnt = 0;
        we_cnt   = 0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        @(negedge clk);
    endtask

    // One ioctl write, honouring ioctl_wait; starts and ends on a falling edge.
    task automatic send_byte(input int off, input logic [7:0] b);
        int guard = 0;
        while (ioctl_wait && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("wait_timeout", 32'(ioctl_wait), 32'd0);
        ioctl_addr = 25'(off);
        ioctl_dout = b;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic compare_log(input string name, input vec_t v);
        check({name, "_nwr"}, 32'(log_q.size()), 32'(v.nexp));
        for (int k = 0; k < int'(v.nexp); k++) begin
            if (k < log_q.size()) begin
                check($sformatf("%s_a%0d", name, k), 32'(log_q[k].a), 32'(v.ea[k]));
                check($sformatf("%s_d%0d", name, k), 32'(log_q[k].d), 32'(v.ed[k]));
            end
        end
        check({name, "_done"}, 32'(done_cnt), 32'(v.edone));
        check({name, "_ovf"}, 32'(overflow), 32'(v.eovf));
    endtask

    task automatic run_vec(input int i);
        vec_t v = vecs[i];
        clear_log();
        start_dl(8'h41);
        for (int k = 0; k < int'(v.nbytes); k++) send_byte(k, v.bytes[k]);
        end_dl();
        wait_idle($sformatf("v%0d", i));
        compare_log($sformatf("v%0d", i), v);
    endtask

    initial begin
        // Header 01 04, payload AA BB CC.
        vecs[0] = '0;
        vecs[0].nbytes = 4'd5;
        vecs[0].bytes[0] = 8'h01; vecs[0].bytes[1] = 8'h04;
        vecs[0].bytes[2] = 8'hAA; vecs[0].bytes[3] = 8'hBB; vecs[0].bytes[4] = 8'hCC;
        vecs[0].nexp = 4'd5;
        vecs[0].ea[0] = 16'h0401; vecs[0].ed[0] = 8'hAA;
        vecs[0].ea[1] = 16'h0402; vecs[0].ed[1] = 8'hBB;
        vecs[0].ea[2] = 16'h0403; vecs[0].ed[2] = 8'hCC;
        vecs[0].ea[3] = 16'h002A; vecs[0].ed[3] = 8'h04;
        vecs[0].ea[4] = 16'h002B; vecs[0].ed[4] = 8'h04;
        vecs[0].edone = 1'b1; vecs[0].eovf = 1'b0;
        // Header FE 7F, payload truncated at LIMIT.
        vecs[1] = '0;
        vecs[1].nbytes = 4'd6;
        vecs[1].bytes[0] = 8'hFE; vecs[1].bytes[1] = 8'h7F;
        vecs[1].bytes[2] = 8'h11; vecs[1].bytes[3] = 8'h22;
        vecs[1].bytes[4] = 8'h33; vecs[1].bytes[5] = 8'h44;
        vecs[1].nexp = 4'd4;
        vecs[1].ea[0] = 16'h7FFE; vecs[1].ed[0] = 8'h11;
        vecs[1].ea[1] = 16'h7FFF; vecs[1].ed[1] = 8'h22;
        vecs[1].ea[2] = 16'h002A; vecs[1].ed[2] = 8'h00;
        vecs[1].ea[3] = 16'h002B; vecs[1].ed[3] = 8'h80;
        vecs[1].edone = 1'b1; vecs[1].eovf = 1'b1;
        // One-byte file: too short, nothing written; overflow cleared by new load.
        vecs[2] = '0;
        vecs[2].nbytes = 4'd1;
        vecs[2].bytes[0] = 8'h01;
        vecs[2].nexp = 4'd0;
        vecs[2].edone = 1'b0; vecs[2].eovf = 1'b0;
        // Empty payload: pointer equals the header address.
        vecs[3] = '0;
        vecs[3].nbytes = 4'd2;
        vecs[3].bytes[0] = 8'h34; vecs[3].bytes[1] = 8'h12;
        vecs[3].nexp = 4'd2;
        vecs[3].ea[0] = 16'h002A; vecs[3].ed[0] = 8'h34;
        vecs[3].ea[1] = 16'h002B; vecs[3].ed[1] = 8'h12;
        vecs[3].edone = 1'b1; vecs[3].eovf = 1'b0;
        // Header above LIMIT: payload dropped, pointer is the header address.
        vecs[4] = '0;
        vecs[4].nbytes = 4'd3;
        vecs[4].bytes[0] = 8'h00; vecs[4].bytes[1] = 8'h90; vecs[4].bytes[2] = 8'h55;
        vecs[4].nexp = 4'd2;
        vecs[4].ea[0] = 16'h002A; vecs[4].ed[0] = 8'h00;
        vecs[4].ea[1] = 16'h002B; vecs[4].ed[1] = 8'h90;
        vecs[4].edone = 1'b1; vecs[4].eovf = 1'b1;

        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_we", 32'(dma_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_addr", 32'(dma_addr), 32'd0);
        check("rst_din", 32'(dma_din), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(i);

        // DMA stalled for 10 cycles: ioctl_wait tracks the FIFO fill level.
        clear_log();
        start_dl(8'h41);
        send_byte(0, 8'h01);
        send_byte(1, 8'h04);
        stall_until = cyc + 10;
        send_byte(2, 8'hAA);
        send_byte(3, 8'hBB);
        check("stall_wait_cnt2", 32'(ioctl_wait), 32'd0);
        send_byte(4, 8'hCC);
        check("stall_wait_cnt3", 32'(ioctl_wait), 32'd1);
        check("stall_we_held", 32'(dma_we), 32'd1);
        end_dl();
        wait_idle("stall");
        compare_log("stall", vecs[0]);

        // Async reset in DRAIN with two entries queued.
        clear_log();
        ack_en = 1'b0;
        start_dl(8'h41);
        send_byte(0, 8'h00);
        send_byte(1, 8'h10);
        send_byte(2, 8'h01);
        send_byte(3, 8'h02);
        end_dl();
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_wait", 32'(ioctl_wait), 32'd1);
        check("drain_we", 32'(dma_we), 32'd1);
        check("drain_head", 32'(dma_addr), 32'h1000);
        reset = 1'b1;
        #1;
        check("arst_we", 32'(dma_we), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_wait", 32'(ioctl_wait), 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        ack_en = 1'b1;
        repeat (4) @(negedge clk);
        check("arst_nwr", 32'(log_q.size()), 32'd0);
        check("arst_done", 32'(done_cnt), 32'd0);
        check("arst_we_after", 32'(dma_we), 32'd0);
        run_vec(0);

        // Foreign index: ignored entirely.
        clear_log();
        start_dl(8'h01);
        for (int k = 0; k < 4; k++) begin
            send_byte(k, 8'(8'h50 + k));
            check($sformatf("idx_busy%0d", k), 32'(busy), 32'd0);
            check($sformatf("idx_wait%0d", k), 32'(ioctl_wait), 32'd0);
        end
        end_dl();
        repeat (5) @(negedge clk);
        check("idx_we_cnt", 32'(we_cnt), 32'd0);
        check("idx_done", 32'(done_cnt), 32'd0);
        check("idx_busy_end", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
